// File: rtl/data_mem_responder.sv
// Multi-cycle MEM-stage data memory: 32/64-bit accesses with WAIT_CYCLES added latency.
// Define DMEM_BYTE_STORE_EN to enable big-endian byte stores qualified by req_byte.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_addr,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_write64,
    input  logic        req_dbl,
    input  logic        req_byte,
    input  logic [31:0] req_wdata,
    input  logic [63:0] req_wdata64,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_nextdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        mem_stall
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StAcc0 = 3'd2;
    localparam logic [2:0] StAcc1 = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [63:0]   wdata64_q, wdata64_d;
    logic          wr_q, wr_d;
    logic          dbl_q, dbl_d;
    logic          byte_q, byte_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [31:0]   rsp_next_q, rsp_next_d;

    logic [31:0]   mem_q [DEPTH];

    logic          req_any;
    logic          dec_wr;
    logic          dec_dbl;
    logic          dec_byte;
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [1:0]    lane;
    logic          misal;
    logic [31:0]   word_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Upper address bits alias onto the array; req_byte is unused without byte stores.
    logic unused_inputs;
    assign unused_inputs = ^{req_addr[31:AW+2], req_byte};

    assign req_any = req_read | req_write | req_write64;
    assign dec_wr  = req_write | req_write64;
    // A write beats a simultaneous read, so req_dbl only matters for a pure read.
    assign dec_dbl = req_write64 | (~dec_wr & req_dbl);

`ifdef DMEM_BYTE_STORE_EN
    assign dec_byte = req_byte & ~dec_dbl;
`else
    assign dec_byte = 1'b0;
`endif

    assign idx0  = addr_q[AW+1:2];
    assign idx1  = idx0 + 1'b1;
    assign lane  = addr_q[1:0];
    assign misal = (|lane) & ~byte_q;

    // Word to store for a 32-bit write; byte stores merge into the current word.
    always_comb begin
        word_wdata = wdata_q;
`ifdef DMEM_BYTE_STORE_EN
        if (byte_q) begin
            word_wdata = mem_q[idx0];
            unique case (lane)
                2'd0: word_wdata[31:24] = wdata_q[7:0];
                2'd1: word_wdata[23:16] = wdata_q[7:0];
                2'd2: word_wdata[15:8]  = wdata_q[7:0];
                2'd3: word_wdata[7:0]   = wdata_q[7:0];
                default: word_wdata = mem_q[idx0];
            endcase
        end
`endif
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx0;
        mem_wdata = word_wdata;
        if (wr_q && !misal) begin
            if (state_q == StAcc0) begin
                mem_we    = 1'b1;
                mem_wdata = dbl_q ? wdata64_q[63:32] : word_wdata;
            end else if (state_q == StAcc1) begin
                mem_we    = 1'b1;
                mem_waddr = idx1;
                mem_wdata = wdata64_q[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wdata64_d  = wdata64_q;
        wr_d       = wr_q;
        dbl_d      = dbl_q;
        byte_d     = byte_q;
        rsp_data_d = rsp_data_q;
        rsp_next_d = rsp_next_q;
        case (state_q)
            StIdle: begin
                if (req_any) begin
                    addr_d    = req_addr[AW+1:0];
                    wdata_d   = req_wdata;
                    wdata64_d = req_wdata64;
                    wr_d      = dec_wr;
                    dbl_d     = dec_dbl;
                    byte_d    = dec_byte;
                    cnt_d     = WaitLoad;
                    state_d   = (WAIT_CYCLES == 0) ? StAcc0 : StWait;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAcc0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAcc0: begin
                rsp_data_d = (!wr_q && !misal) ? mem_q[idx0] : 32'h0;
                rsp_next_d = 32'h0;
                state_d    = dbl_q ? StAcc1 : StDone;
            end
            StAcc1: begin
                if (!wr_q && !misal) begin
                    rsp_next_d = mem_q[idx1];
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            wdata64_q  <= 64'h0;
            wr_q       <= 1'b0;
            dbl_q      <= 1'b0;
            byte_q     <= 1'b0;
            rsp_data_q <= 32'h0;
            rsp_next_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdata64_q  <= wdata64_d;
            wr_q       <= wr_d;
            dbl_q      <= dbl_d;
            byte_q     <= byte_d;
            rsp_data_q <= rsp_data_d;
            rsp_next_q <= rsp_next_d;
        end
    end

    assign rsp_data     = rsp_data_q;
    assign rsp_nextdata = rsp_next_q;
    assign rsp_valid    = (state_q == StDone);
    assign rsp_err      = (state_q == StDone) & misal;
    // Gated by rst_n so the stall drops immediately while reset is held.
    assign mem_stall    = rst_n & (((state_q == StIdle) & req_any) | (state_q == StWait) |
                                   (state_q == StAcc0) | (state_q == StAcc1));

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table driven through a scoreboard,
// plus hand sequences for reset mid-access and response hold.
module tb_data_mem_responder;

    localparam int W = 2;
    localparam int D = 256;

    localparam int K_RD32 = 0;
    localparam int K_RD64 = 1;
    localparam int K_WR32 = 2;
    localparam int K_WR64 = 3;
    localparam int K_RW   = 4;
    localparam int K_BWR  = 5;
    localparam int K_BRD  = 6;

`ifdef DMEM_BYTE_STORE_EN
    localparam logic        BYTE_ERR  = 1'b0;
    localparam logic [31:0] BYTE_WORD = 32'h00AB0000;
`else
    localparam logic        BYTE_ERR  = 1'b1;
    localparam logic [31:0] BYTE_WORD = 32'h00000000;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] req_addr;
    logic        req_read;
    logic        req_write;
    logic        req_write64;
    logic        req_dbl;
    logic        req_byte;
    logic [31:0] req_wdata;
    logic [63:0] req_wdata64;
    logic [31:0] rsp_data;
    logic [31:0] rsp_nextdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic        mem_stall;

    data_mem_responder #(
        .DEPTH      (D),
        .WAIT_CYCLES(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_write64 (req_write64),
        .req_dbl     (req_dbl),
        .req_byte    (req_byte),
        .req_wdata   (req_wdata),
        .req_wdata64 (req_wdata64),
        .rsp_data    (rsp_data),
        .rsp_nextdata(rsp_nextdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .mem_stall   (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [31:0] ed;
        logic [31:0] en;
        logic        ee;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [31:0] next;
        logic        err;
        int          lat;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Called right after a rising edge; the request is presented for one cycle only.
    task automatic issue(input string tag, input vec_t v, input bit push);
        exp_t e;
        #1;
        req_addr    = v.addr;
        req_wdata   = v.wd[31:0];
        req_wdata64 = v.wd;
        req_read    = (v.kind == K_RD32) || (v.kind == K_RD64) || (v.kind == K_RW) ||
                      (v.kind == K_BRD);
        req_write   = (v.kind == K_WR32) || (v.kind == K_RW) || (v.kind == K_BWR);
        req_write64 = (v.kind == K_WR64);
        req_dbl     = (v.kind == K_RD64);
        req_byte    = (v.kind == K_BWR) || (v.kind == K_BRD);
        if (push) begin
            e.tag  = tag;
            e.data = v.ed;
            e.next = v.en;
            e.err  = v.ee;
            e.lat  = ((v.kind == K_RD64) || (v.kind == K_WR64)) ? W + 3 : W + 2;
            e.cyc  = cyc + 1 + e.lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the request fields so the DUT must rely on its latched copy.
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_write64 = 1'b0;
        req_addr    = $urandom;
        req_wdata   = $urandom;
        req_wdata64 = {$urandom, $urandom};
        req_dbl     = 1'($urandom);
        req_byte    = 1'($urandom);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 40);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending responses, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rsp_valid=1, required 0");
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_data"}, 64'(rsp_data), 64'(e.data));
                    chk({e.tag, "_next"}, 64'(rsp_nextdata), 64'(e.next));
                    chk({e.tag, "_err"}, 64'(rsp_err), 64'(e.err));
                    chk({e.tag, "_latency"}, 64'(cyc), 64'(e.cyc));
                    chk({e.tag, "_stall_cycles"}, 64'(stall_run), 64'(e.lat));
                    chk({e.tag, "_stall_in_done"}, 64'(mem_stall), 64'(0));
                end
                stall_run = 0;
            end else if (mem_stall) begin
                stall_run++;
            end else begin
                stall_run = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vecs.push_back('{K_WR32, 32'h010, 64'h00000000DEADBEEF, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{K_RD32, 32'h010, 64'h0, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{K_WR64, 32'h020, 64'h1122334455667788, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{K_RD64, 32'h020, 64'h0, 32'h11223344, 32'h55667788, 1'b0});
        vecs.push_back('{K_RD32, 32'h024, 64'h0, 32'h55667788, 32'h0, 1'b0});
        vecs.push_back('{K_WR64, 32'h3FC, 64'hAAAA0001BBBB0002, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{K_RD32, 32'h3FC, 64'h0, 32'hAAAA0001, 32'h0, 1'b0});
        vecs.push_back('{K_RD32, 32'h000, 64'h0, 32'hBBBB0002, 32'h0, 1'b0});
        vecs.push_back('{K_RD64, 32'h3FC, 64'h0, 32'hAAAA0001, 32'hBBBB0002, 1'b0});
        vecs.push_back('{K_RD32, 32'h013, 64'h0, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{K_WR32, 32'h013, 64'h0000000012345678, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{K_RD32, 32'h010, 64'h0, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{K_RD32, 32'h410, 64'h0, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{K_RD64, 32'h022, 64'h0, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{K_RW,   32'h030, 64'h00000000CAFEF00D, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{K_RD32, 32'h030, 64'h0, 32'hCAFEF00D, 32'h0, 1'b0});
        vecs.push_back('{K_WR32, 32'h040, 64'h0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{K_BWR,  32'h041, 64'h00000000000000AB, 32'h0, 32'h0, BYTE_ERR});
        vecs.push_back('{K_RD32, 32'h040, 64'h0, BYTE_WORD, 32'h0, 1'b0});
        vecs.push_back('{K_BRD,  32'h043, 64'h0, BYTE_WORD, 32'h0, BYTE_ERR});

        rst_n       = 1'b0;
        req_addr    = 32'h0;
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_write64 = 1'b0;
        req_dbl     = 1'b0;
        req_byte    = 1'b0;
        req_wdata   = 32'h0;
        req_wdata64 = 64'h0;
        #2;
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_rsp_nextdata", 64'(rsp_nextdata), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_err", 64'(rsp_err), 64'(0));
        chk("reset_mem_stall", 64'(mem_stall), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Each request is issued in the cycle right after the previous DONE.
        for (int i = 0; i < vecs.size(); i++) begin
            issue($sformatf("vec%0d", i), vecs[i], 1'b1);
            drain($sformatf("vec%0d", i));
        end

        // Reset asserted while a read sits in WAIT.
        v = '{K_RD32, 32'h010, 64'h0, 32'h0, 32'h0, 1'b0};
        issue("rst_read", v, 1'b0);
        #2;
        chk("stall_in_wait", 64'(mem_stall), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 64'(mem_stall), 64'(0));
        chk("rst_mid_valid", 64'(rsp_valid), 64'(0));
        chk("rst_mid_data", 64'(rsp_data), 64'(0));
        repeat (2) @(negedge clk);
        chk("rst_hold_valid", 64'(rsp_valid), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        v = '{K_RD32, 32'h010, 64'h0, 32'hDEADBEEF, 32'h0, 1'b0};
        issue("post_rst_read", v, 1'b1);
        drain("post_rst_read");

        // Response data holds while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        chk("hold_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("hold_mem_stall", 64'(mem_stall), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the MEM stage of the 5-stage MIPS pipeline. Accepts 32-bit and 64-bit (paired-word, FP double) read/write requests from the EXE/MEM register outputs, holds the pipeline with a stall while the configurable access latency elapses, then returns read data in the layout the MEM/WB register expects. It is the memory side of the MEM-stage request interface and replaces the single-cycle data memory when realistic latency is modelled.

## Interface
Parameters:
- DEPTH, 256, memory size in 32-bit words (power of two)
- WAIT_CYCLES, 2, added access latency in cycles (0..15)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_addr  in  32  byte address from EXE/MEM
- req_read  in  1  32-bit or 64-bit read request
- req_write  in  1  32-bit write request
- req_write64  in  1  64-bit write request
- req_dbl  in  1  read is 64-bit (paired word)
- req_byte  in  1  byte store/load qualifier (see Configuration)
- req_wdata  in  32  write data for 32-bit/byte writes
- req_wdata64  in  64  write data for 64-bit writes
- rsp_data  out  32  word at req_addr
- rsp_nextdata  out  32  word at req_addr+4 (valid for 64-bit reads)
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_err  out  1  one-cycle pulse with rsp_valid: misaligned access
- mem_stall  out  1  hold PC, IF/ID, ID/EXE, EXE/MEM

## Operation
- Word index w = req_addr[31:2] mod DEPTH; second word (w+1) mod DEPTH, wraps DEPTH-1 -> 0.
- Request = req_read | req_write | req_write64. Write wins when read and write asserted together: write performed, rsp_data/rsp_nextdata = 0.
- Request fields latched on acceptance; later input changes ignored until DONE.
- FSM: IDLE -> (request) WAIT -> ACC0 -> [ACC1 if 64-bit] -> DONE -> IDLE. WAIT_CYCLES=0: IDLE -> ACC0 directly. WAIT counts down a 4-bit counter loaded with WAIT_CYCLES-1.
- ACC0: read mem[w] into rsp_data, or write. 32-bit write: mem[w]=wdata. 64-bit write: mem[w]=wdata64[63:32].
- ACC1: read mem[w+1] into rsp_nextdata, or mem[w+1]=wdata64[31:0].
- 32-bit read: rsp_nextdata = 0.
- Misaligned (req_addr[1:0]!=0 and not a byte op): no array access, rsp_data/rsp_nextdata = 0, rsp_err=1 in DONE; latency unchanged.
- DONE: rsp_valid=1; requests present in DONE are not accepted (the advancing instruction's request is retired). Return to IDLE next cycle.
- rsp_data/rsp_nextdata hold their values until the next access's ACC0.
- Array contents not cleared by reset.

## Timing
- Reset values: rsp_data=0, rsp_nextdata=0, rsp_valid=0, rsp_err=0, mem_stall=0, state=IDLE.
- mem_stall combinational: high in IDLE when a request is present, and in WAIT/ACC0/ACC1; low in DONE and idle IDLE.
- Request accepted at edge T0: rsp_valid high during cycle T0+WAIT_CYCLES+2 (32-bit) or T0+WAIT_CYCLES+3 (64-bit); mem_stall high for WAIT_CYCLES+2 / +3 cycles.
- Back-to-back: a request in the cycle after DONE is accepted; minimum issue interval WAIT_CYCLES+3 cycles (32-bit).
- rst_n low mid-access: FSM to IDLE immediately, stall and pulses drop asynchronously; an in-flight ACC1 not yet executed is lost (partial 64-bit write permitted).

## Configuration
- DMEM_BYTE_STORE_EN defined: req_byte with req_write writes req_wdata[7:0] into byte lane req_addr[1:0] of mem[w], big-endian (lane 0 = bits 31:24), other lanes preserved; req_byte with req_read returns the containing word; no misalignment error for byte ops.
- Undefined: req_byte ignored; all accesses treated as word accesses and subject to the misalignment check.

## Test plan
- WAIT_CYCLES=2: write 0xDEADBEEF at 0x10, read 0x10 -> rsp_data=0xDEADBEEF, rsp_valid 4 cycles after acceptance, mem_stall high exactly 4 cycles.
- 64-bit write 0x11223344_55667788 at 0x20, 64-bit read -> rsp_data=0x11223344, rsp_nextdata=0x55667788, stall 5 cycles.
- DEPTH=256, 64-bit write at 0x3FC -> mem[255]=high word, mem[0]=low word; reads of 0x3FC and 0x0 confirm.
- Read at 0x13 -> rsp_err=1 with rsp_valid, rsp_data=0, memory unchanged.
- With DMEM_BYTE_STORE_EN: word 0x00000000 at 0x40, byte store 0xAB at 0x41 -> read 0x40 returns 0x00AB0000; without macro same stimulus -> rsp_err=1.
- rst_n low during WAIT of a read -> mem_stall=0, rsp_valid=0 immediately; new read after release completes with normal latency.
